adder_axil_master: RTL and testbench
====================================

Name: adder_axil_master

Overview:
- AXI4-Lite master that drives the memory-mapped adder peripheral directly downstream of it.
- Takes a one-shot command (operand A, operand B) from local logic.
- Executes four bus transactions in order: write A to 0x00, write B to 0x04, read result from 0x08, read overflow flag from 0x0C.
- Returns sum, overflow and status to the requester, with a per-transaction timeout.

Parameters:
- DATA_WIDTH, 32, bus data width and operand width.
- ADDR_WIDTH, 8, bus address width.
- TIMEOUT_CYCLES, 256, max cycles to wait for any single handshake before aborting; must be ≥2.

Ports:
- m1_axi_aclk  in  1  clock.
- m1_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  start request.
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
- cmd_opa  in  DATA_WIDTH  operand A.
- cmd_opb  in  DATA_WIDTH  operand B.
- rsp_valid  out  1  one-cycle pulse, result fields valid.
- rsp_sum  out  DATA_WIDTH  value read from 0x08.
- rsp_ovf  out  1  bit 0 of value read from 0x0C.
- rsp_err  out  1  set if any response was not OKAY or a timeout occurred.
- m1_axi_awaddr  out  ADDR_WIDTH  write address.
- m1_axi_awvalid  out  1.
- m1_axi_awready  in  1.
- m1_axi_wdata  out  DATA_WIDTH.
- m1_axi_wstrb  out  DATA_WIDTH/8  always all ones.
- m1_axi_wvalid  out  1.
- m1_axi_wready  in  1.
- m1_axi_bresp  in  2.
- m1_axi_bvalid  in  1.
- m1_axi_bready  out  1.
- m1_axi_araddr  out  ADDR_WIDTH.
- m1_axi_arvalid  out  1.
- m1_axi_arready  in  1.
- m1_axi_rdata  in  DATA_WIDTH.
- m1_axi_rresp  in  2.
- m1_axi_rvalid  in  1.
- m1_axi_rready  out  1.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all valid/ready outputs 0; cmd_ready 1.
  - rsp_* 0; addr/data 0; timeout counter 0.
- All outputs are registered.

FSM states: IDLE, WR_A, WR_B, B_WAIT, RD_RES, RD_OVF, R_WAIT, DONE.
- IDLE:
  - On cmd_valid, latch opa/opb, clear err flag, cmd_ready←0, go WR_A.
  - Next cycle awvalid=wvalid=1, awaddr=0x00, wdata=opa.
- WR_A / WR_B:
  - AW and W are tracked independently. Each valid drops the cycle after its own ready is seen; the other is held until its own handshake.
  - Simultaneous awready&wready completes both in one cycle.
  - When both have completed: bready←1, go B_WAIT.
- B_WAIT:
  - On bvalid&bready: bready←0; if bresp≠2'b00 set err.
  - After A: go WR_B with awaddr=0x04, wdata=opb.
  - After B: go RD_RES with arvalid=1, araddr=0x08.
- RD_RES / RD_OVF:
  - Hold arvalid until arready; then arvalid←0, rready←1, go R_WAIT.
- R_WAIT:
  - On rvalid&rready: rready←0; capture rdata (sum) or rdata[0] (ovf); rresp≠OKAY sets err.
  - After RES go RD_OVF with araddr=0x0C; after OVF go DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_* hold until the next command is accepted.
  - Then go IDLE, cmd_ready←1.
- Error responses do not abort the sequence; all four transactions still run.
- Timeout:
  - Counter clears on each state entry and increments while waiting on any handshake.
  - Reaching TIMEOUT_CYCLES-1: drop all valid/ready outputs, set err, go DONE. rsp_sum is 0 if the result was not yet read.
- Latency with a zero-wait slave: command accept to rsp_valid = 11 cycles (2 per write address/data + 1 per B, 1 per AR + 1 per R, + DONE). The bench measures it; the spec fixes it.
- cmd_valid outside IDLE is ignored. Reset mid-sequence returns to IDLE with no bus valids asserted.
- Address/data outputs are stable while their valid is high.

Decomposition:
- Package adder_axil_pkg:
  - register offsets ADDR_OPA=0, ADDR_OPB=4, ADDR_RES=8, ADDR_OVF=12.
  - AXI response codes OKAY=2'b00, SLVERR=2'b10.
  - FSM state enum.
- Shared with the slave side so offsets live in one place.
- One sub-module: axil_write_chan, which issues one AW+W pair with independent handshakes and a done pulse. It is instantiated once and reused for both writes.

Test Plan:
- Zero-wait slave, opa=5, opb=7 → writes 0x00=5, 0x04=7; reads 0x08 return 12 and 0x0C return 0; rsp_sum=12, rsp_ovf=0, rsp_err=0, rsp_valid 11 cycles after accept.
- opa=0xFFFF_FFFF, opb=1, slave returns sum 0 and ovf 1 → rsp_sum=0, rsp_ovf=1, rsp_err=0.
- wready delayed 3 cycles after awready → awvalid drops after its handshake, wvalid held 3 cycles, wdata stable; sequence completes correctly.
- Slave returns bresp=2'b10 on the B write → all four transactions still run, rsp_err=1.
- arready never asserted on 0x08 → arvalid drops after TIMEOUT_CYCLES, rsp_valid with rsp_err=1, rsp_sum=0, cmd_ready back to 1.
- Reset asserted mid-WR_B → all valids 0 asynchronously; after release a new command (3,4) yields rsp_sum=7.

Source files
------------

// File: rtl/adder_axil_pkg.sv
// Shared definitions for the adder peripheral and its AXI4-Lite master:
// register map, AXI response codes and master FSM state encoding.
package adder_axil_pkg;

    // Register map of the adder peripheral (byte offsets).
    localparam logic [7:0] ADDR_OPA = 8'h00;
    localparam logic [7:0] ADDR_OPB = 8'h04;
    localparam logic [7:0] ADDR_RES = 8'h08;
    localparam logic [7:0] ADDR_OVF = 8'h0C;

    // AXI response codes used by the peripheral.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Master FSM states.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WR_A   = 3'd1;
    localparam state_t ST_WR_B   = 3'd2;
    localparam state_t ST_B_WAIT = 3'd3;
    localparam state_t ST_RD_RES = 3'd4;
    localparam state_t ST_RD_OVF = 3'd5;
    localparam state_t ST_R_WAIT = 3'd6;
    localparam state_t ST_DONE   = 3'd7;

endpackage

// File: rtl/axil_write_chan.sv
// Issues one AXI4-Lite AW+W pair. The two channels handshake independently:
// each valid drops after its own ready, and a one-cycle done pulse follows
// once both have completed. An abort drops both valids immediately.
module axil_write_chan #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  done
);

    logic busy;
    logic aw_done;
    logic w_done;
    logic aw_ok;
    logic w_ok;

    // A channel counts as complete if it finished earlier or handshakes now.
    assign aw_ok = aw_done | (awvalid & awready);
    assign w_ok  = w_done  | (wvalid  & wready);

    // Channel handshake tracking; address/data are held once loaded so they
    // stay stable for as long as their valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= addr;
                wdata   <= data;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (abort) begin
                busy    <= 1'b0;
                awvalid <= 1'b0;
                wvalid  <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (busy) begin
                if (awvalid && awready) begin
                    awvalid <= 1'b0;
                    aw_done <= 1'b1;
                end
                if (wvalid && wready) begin
                    wvalid <= 1'b0;
                    w_done <= 1'b1;
                end
                // NOTE: non-blocking assignments take the last value written in
                // the block, so this completion branch cleanly overrides the
                // per-channel done flags set just above.
                if (aw_ok && w_ok) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/adder_axil_master.sv
// AXI4-Lite master for the adder peripheral. One command runs four bus
// transactions in order (write A, write B, read sum, read overflow) and
// returns sum/overflow/error with a one-cycle rsp_valid pulse. Every
// handshake wait is bounded by TIMEOUT_CYCLES.
module adder_axil_master
    import adder_axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_opa,
    input  logic [DATA_WIDTH-1:0]   cmd_opb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_ovf,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [1:0]              m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [1:0]              m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic                    phase_b;   // second write (B) / second read (OVF)
    logic [TMO_W-1:0]        tmo;
    logic [DATA_WIDTH-1:0]   opb_q;
    logic [DATA_WIDTH-1:0]   sum_q;
    logic                    ovf_q;
    logic                    err_q;

    logic                    accept;
    logic                    waiting;
    logic                    tmo_hit;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    wr_start;
    logic                    wr_done;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    assign accept  = cmd_valid & cmd_ready;
    assign waiting = (state != ST_IDLE) && (state != ST_DONE);
    assign tmo_hit = waiting && (tmo == TMO_MAX);
    assign b_hs    = m1_axi_bvalid  & m1_axi_bready;
    assign ar_hs   = m1_axi_arvalid & m1_axi_arready;
    assign r_hs    = m1_axi_rvalid  & m1_axi_rready;

    // Write A starts straight from the accepted command; write B starts on
    // the B response of write A. A timeout takes priority over both.
    assign wr_start = accept ||
                      ((state == ST_B_WAIT) && b_hs && !phase_b && !tmo_hit);
    assign wr_addr  = (state == ST_IDLE) ? ADDR_WIDTH'(ADDR_OPA) : ADDR_WIDTH'(ADDR_OPB);
    assign wr_data  = (state == ST_IDLE) ? cmd_opa : opb_q;

    assign m1_axi_wstrb = '1;

    axil_write_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr (
        .clk     (m1_axi_aclk),
        .rst_n   (m1_axi_aresetn),
        .start   (wr_start),
        .abort   (tmo_hit),
        .addr    (wr_addr),
        .data    (wr_data),
        .awaddr  (m1_axi_awaddr),
        .awvalid (m1_axi_awvalid),
        .awready (m1_axi_awready),
        .wdata   (m1_axi_wdata),
        .wvalid  (m1_axi_wvalid),
        .wready  (m1_axi_wready),
        .done    (wr_done)
    );

    // Sequencer: walks the four transactions, accumulates the error flag and
    // publishes the response; the timeout counter restarts on every state change.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state          <= ST_IDLE;
            phase_b        <= 1'b0;
            tmo            <= '0;
            opb_q          <= '0;
            sum_q          <= '0;
            ovf_q          <= 1'b0;
            err_q          <= 1'b0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_sum        <= '0;
            rsp_ovf        <= 1'b0;
            rsp_err        <= 1'b0;
            m1_axi_bready  <= 1'b0;
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            tmo       <= waiting ? tmo + 1'b1 : '0;
            if (tmo_hit) begin
                m1_axi_bready  <= 1'b0;
                m1_axi_arvalid <= 1'b0;
                m1_axi_rready  <= 1'b0;
                err_q          <= 1'b1;
                tmo            <= '0;
                state          <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            opb_q     <= cmd_opb;
                            sum_q     <= '0;
                            ovf_q     <= 1'b0;
                            err_q     <= 1'b0;
                            phase_b   <= 1'b0;
                            cmd_ready <= 1'b0;
                            state     <= ST_WR_A;
                        end
                    end
                    ST_WR_A, ST_WR_B: begin
                        if (wr_done) begin
                            m1_axi_bready <= 1'b1;
                            tmo           <= '0;
                            state         <= ST_B_WAIT;
                        end
                    end
                    ST_B_WAIT: begin
                        if (b_hs) begin
                            m1_axi_bready <= 1'b0;
                            tmo           <= '0;
                            if (m1_axi_bresp != RESP_OKAY) err_q <= 1'b1;
                            if (!phase_b) begin
                                phase_b <= 1'b1;
                                state   <= ST_WR_B;
                            end else begin
                                phase_b        <= 1'b0;
                                m1_axi_arvalid <= 1'b1;
                                m1_axi_araddr  <= ADDR_WIDTH'(ADDR_RES);
                                state          <= ST_RD_RES;
                            end
                        end
                    end
                    ST_RD_RES, ST_RD_OVF: begin
                        if (ar_hs) begin
                            m1_axi_arvalid <= 1'b0;
                            m1_axi_rready  <= 1'b1;
                            tmo            <= '0;
                            state          <= ST_R_WAIT;
                        end
                    end
                    ST_R_WAIT: begin
                        if (r_hs) begin
                            m1_axi_rready <= 1'b0;
                            tmo           <= '0;
                            if (m1_axi_rresp != RESP_OKAY) err_q <= 1'b1;
                            if (!phase_b) begin
                                sum_q          <= m1_axi_rdata;
                                phase_b        <= 1'b1;
                                m1_axi_arvalid <= 1'b1;
                                m1_axi_araddr  <= ADDR_WIDTH'(ADDR_OVF);
                                state          <= ST_RD_OVF;
                            end else begin
                                ovf_q <= m1_axi_rdata[0];
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        rsp_valid <= 1'b1;
                        rsp_sum   <= sum_q;
                        rsp_ovf   <= ovf_q;
                        rsp_err   <= err_q;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adder_axil_master.sv
// Self-checking bench for adder_axil_master: a behavioural adder peripheral
// answers the bus, and every response is compared against plain 33-bit
// addition of the commanded operands plus the expected transaction list.
module tb_adder_axil_master;
    import adder_axil_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int TMO    = 256;
    localparam int BUDGET = TMO * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [DW-1:0] cmd_opa, cmd_opb;
    logic          rsp_valid, rsp_ovf, rsp_err;
    logic [DW-1:0] rsp_sum;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
        .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
        .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
    );

    // ---------------- behavioural adder peripheral ----------------
    logic          wdelay_en = 1'b0;   // wready waits 3 cycles after AW
    logic          bresp_err_en = 1'b0; // SLVERR on the write to 0x04
    logic          blk_res_en = 1'b0;  // never accept AR to 0x08
    logic          aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d;
    int            aw_age;
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    logic [DW:0]   full_sum;
    logic [40:0]   log_q[$];           // {is_write, addr, data}

    assign full_sum = {1'b0, reg_a} + {1'b0, reg_b};
    assign awready  = 1'b1;
    assign wready   = !wdelay_en || (aw_got && aw_age >= 2);
    assign arready  = !(blk_res_en && araddr == ADDR_RES);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_age <= 0; aw_a <= '0; w_d <= '0;
            bvalid <= 1'b0; bresp <= RESP_OKAY; rvalid <= 1'b0; rdata <= '0; rresp <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_a <= awaddr; aw_age <= 0;
            end else if (aw_got) begin
                aw_age <= aw_age + 1;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; w_d <= wdata;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= (bresp_err_en && aw_a == ADDR_OPB) ? RESP_SLVERR : RESP_OKAY;
                if (aw_a == ADDR_OPA) reg_a <= w_d;
                else if (aw_a == ADDR_OPB) reg_b <= w_d;
                log_q.push_back({1'b1, aw_a, w_d});
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= RESP_OKAY;
                rdata  <= (araddr == ADDR_RES) ? full_sum[DW-1:0] :
                          (araddr == ADDR_OVF) ? {{(DW-1){1'b0}}, full_sum[DW]} : '0;
                log_q.push_back({1'b0, araddr, 32'h0});
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- bus monitor (cumulative counters) ----------------
    int            ar8_cnt = 0, wonly_cnt = 0, unstable_cnt = 0;
    logic          p_wv = 1'b0, p_awv = 1'b0;
    logic [DW-1:0] p_wd = '0;
    logic [AW-1:0] p_awa = '0;

    always @(negedge clk) begin
        if (arvalid && araddr == ADDR_RES) ar8_cnt <= ar8_cnt + 1;
        if (wvalid && !awvalid) wonly_cnt <= wonly_cnt + 1;
        if ((wvalid && p_wv && wdata != p_wd) || (awvalid && p_awv && awaddr != p_awa))
            unstable_cnt <= unstable_cnt + 1;
        p_wv <= wvalid; p_wd <= wdata; p_awv <= awvalid; p_awa <= awaddr;
    end

    // ---------------- reference model and helpers ----------------
    int log_base, ar_base, wo_base, us_base;

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command; junk>0 keeps cmd_valid high with other operands for
    // that many cycles after acceptance. lat = cycles from accept to rsp_valid.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input int junk, output int lat);
        int n;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        log_base = log_q.size(); ar_base = ar8_cnt; wo_base = wonly_cnt; us_base = unstable_cnt;
        cmd_opa = a; cmd_opb = b; cmd_valid = 1'b1;
        @(negedge clk);
        check("accept_clears_cmd_ready", cmd_ready, 0);
        if (junk > 0) begin
            cmd_opa = $urandom; cmd_opb = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        while (!rsp_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (n >= junk) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("rsp_within_budget", rsp_valid, 1);
        lat = n;
    endtask

    task automatic check_log(input string tag, input int n_exp, input logic [31:0] a, input logic [31:0] b);
        logic [40:0] exp_e [4];
        int got;
        exp_e[0] = {1'b1, ADDR_OPA, a};
        exp_e[1] = {1'b1, ADDR_OPB, b};
        exp_e[2] = {1'b0, ADDR_RES, 32'h0};
        exp_e[3] = {1'b0, ADDR_OVF, 32'h0};
        got = log_q.size() - log_base;
        check({tag, "_txn_count"}, got, n_exp);
        for (int i = 0; i < n_exp && i < got; i++)
            check($sformatf("%s_txn%0d", tag, i), log_q[log_base + i], exp_e[i]);
    endtask

    task automatic post_rsp(input string tag, input logic [31:0] held_sum);
        @(negedge clk);
        check({tag, "_rsp_one_cycle"}, rsp_valid, 0);
        check({tag, "_cmd_ready_back"}, cmd_ready, 1);
        check({tag, "_rsp_sum_held"}, rsp_sum, held_sum);
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int junk, input bit exp_err, input bit chk_lat);
        int lat;
        logic [32:0] r;
        r = ref_add(a, b);
        run_cmd(a, b, junk, lat);
        if (chk_lat) check({tag, "_latency"}, lat, 11);
        check({tag, "_sum"}, rsp_sum, r[31:0]);
        check({tag, "_ovf"}, rsp_ovf, r[32]);
        check({tag, "_err"}, rsp_err, exp_err);
        check_log(tag, 4, a, b);
        check({tag, "_addr_data_stable"}, unstable_cnt - us_base, 0);
        post_rsp(tag, r[31:0]);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int lat, n;
        logic [31:0] a, b;
        bit e;
        cmd_valid = 1'b0; cmd_opa = '0; cmd_opb = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("rst_rsp", {rsp_sum, rsp_ovf, rsp_err}, 0);
        check("rst_addr_data", {awaddr, wdata, araddr}, 0);
        check("wstrb_all_ones", wstrb, 4'hF);
        rst_n = 1'b1;

        // Zero-wait slave, basic sum.
        do_cmd("basic", 32'd5, 32'd7, 0, 1'b0, 1'b1);
        // Carry out of the top bit.
        do_cmd("carry", 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b1);

        // wready lags awready by 3 cycles on both writes.
        wdelay_en = 1'b1;
        do_cmd("wdelay", 32'h1234_5678, 32'h0F0F_0F0F, 0, 1'b0, 1'b0);
        check("wdelay_w_only_cycles", wonly_cnt - wo_base, 6);
        wdelay_en = 1'b0;

        // SLVERR on write B: sequence still completes, error reported.
        bresp_err_en = 1'b1;
        do_cmd("slverr", 32'd100, 32'd23, 0, 1'b1, 1'b1);
        bresp_err_en = 1'b0;

        // AR to 0x08 never accepted: timeout abort.
        blk_res_en = 1'b1;
        run_cmd(32'd10, 32'd20, 0, lat);
        check("tmo_err", rsp_err, 1);
        check("tmo_sum_zero", rsp_sum, 0);
        check("tmo_ovf_zero", rsp_ovf, 0);
        check("tmo_arvalid_dropped", arvalid, 0);
        check("tmo_arvalid_cycles", ar8_cnt - ar_base, TMO);
        check_log("tmo", 2, 32'd10, 32'd20);
        post_rsp("tmo", 32'd0);
        blk_res_en = 1'b0;

        // Randomized operands, near-overflow boundaries, random SLVERR and
        // cmd_valid held with other operands while busy.
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = 32'hFFFF_FFFF - a + 32'($urandom_range(0, 2));
            e = ($urandom_range(0, 3) == 0);
            bresp_err_en = e;
            do_cmd($sformatf("rand%0d", i), a, b, (i % 2) * 4, e, 1'b1);
        end
        bresp_err_en = 1'b0;

        // Reset in the middle of write B.
        @(negedge clk);
        cmd_opa = 32'd11; cmd_opb = 32'd22; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(awvalid && awaddr == ADDR_OPB) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_wr_b", (awvalid && awaddr == ADDR_OPB), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valids_async", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd("after_reset", 32'd3, 32'd4, 0, 1'b0, 1'b1);
        check("after_reset_sum_7", rsp_sum, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
        $fatal(1);
    end

endmodule
